// File: rtl/bus_ctrl_pkg.sv
// Shared types for the split-capable bus arbiter: FSM state encoding,
// per-slave split tracking states and the master-ID width helper.
package bus_ctrl_pkg;

    // Arbiter FSM states; the encoding is visible on the state output.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SPLIT_REC  = 4'd1,
        ST_SPLIT_WAIT = 4'd2,
        ST_SEARCH_S   = 4'd3,
        ST_SEARCH_M   = 4'd4,
        ST_WAIT_FREE  = 4'd5,
        ST_GRANT      = 4'd6,
        ST_PICKUP     = 4'd7,
        ST_ACK        = 4'd8,
        ST_SETTLE     = 4'd9
    } arb_state_t;

    // Split-slave life cycle: FREE -> BUSY (split held) -> DONE (ready to return).
    typedef enum logic [1:0] {
        SL_FREE = 2'd0,
        SL_BUSY = 2'd1,
        SL_DONE = 2'd2
    } slave_state_t;

    // Width of a master ID; the all-ones value of this width means "no master".
    function automatic int mid_width(input int n_masters);
        return $clog2(n_masters + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: returns the index of the first set request bit found
// when scanning upward (with wrap) from the pointer position.
module rr_picker #(
    parameter int WIDTH = 4,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] pos;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            pos = IW'((int'(ptr) + i) % WIDTH);
            if (req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/split_arbiter.sv
// Priority-group bus arbiter with round-robin inside each group and support
// for split transactions: a slave that splits parks its owning master
// (blocked) until the slave finishes, then the master is regranted and the
// slave receives a one-cycle acknowledge.
//
// Grant handshake: a grant is offered by driving m_grants (one-hot) while in
// PICKUP; the master accepts it by driving the bus, seen as bus_util = 0.
// An offer not accepted within TIMEOUT cycles is withdrawn.
module split_arbiter
    import bus_ctrl_pkg::*;
#(
    parameter int N_MASTERS   = 12,
    parameter int N_PRIO      = 3,
    parameter int N_SLAVES    = 6,
    parameter int TIMEOUT     = 255,
    parameter int WAIT_CYCLES = 2,
    localparam int MW = mid_width(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_MASTERS-1:0] m_reqs,
    output logic [N_MASTERS-1:0] m_grants,
    input  logic                 bus_util,
    input  logic [N_SLAVES-1:0]  slaves_in,
    output logic [N_SLAVES-1:0]  slaves_out,
    output logic [3:0]           state,
    output logic [MW-1:0]        mid_current,
    output logic                 timeout_err
);

    localparam int MPP = N_MASTERS / N_PRIO;
    localparam int PW  = (MPP > 1) ? $clog2(MPP) : 1;
    localparam int GW  = (N_PRIO > 1) ? $clog2(N_PRIO) : 1;
    localparam int SW  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int CW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [MW-1:0] MID_NONE = '1;

    arb_state_t           st_q;
    logic [MW-1:0]        grant_id_q;
    logic [MW-1:0]        mid_q;
    logic [MW-1:0]        target_q;
    logic                 split_ret_q;
    logic [SW-1:0]        tslave_q;
    logic [N_MASTERS-1:0] blocked_q;
    logic [N_MASTERS-1:0] snap_q;
    logic [PW-1:0]        rr_ptr_q [N_PRIO];
    logic [GW-1:0]        win_grp_q;
    logic [PW-1:0]        win_idx_q;
    slave_state_t         sl_st_q  [N_SLAVES];
    logic [MW-1:0]        sl_own_q [N_SLAVES];
    logic                 pend_q;
    logic [SW-1:0]        pend_sl_q;
    logic [TW-1:0]        to_cnt_q;
    logic [CW-1:0]        set_cnt_q;

    logic [N_MASTERS-1:0] elig;
    logic [N_PRIO-1:0]    elig_any;
    logic [N_PRIO-1:0]    pick_v;
    logic [PW-1:0]        pick_idx [N_PRIO];
    logic                 elig_v;
    logic [GW-1:0]        elig_grp;
    logic [GW-1:0]        own_grp;
    logic                 preempt;
    logic                 sel_v;
    logic [GW-1:0]        sel_grp;
    logic [PW-1:0]        sel_idx;
    logic                 done_v;
    logic [SW-1:0]        done_sl;
    logic                 cap_v;
    logic [SW-1:0]        cap_sl;

    assign elig        = m_reqs & ~blocked_q;
    assign state       = st_q;
    assign mid_current = mid_q;

    // Per group: live eligibility summary and a round-robin pick over the snapshot.
    for (genvar g = 0; g < N_PRIO; g++) begin : g_grp
        assign elig_any[g] = |elig[g*MPP +: MPP];
        rr_picker #(.WIDTH(MPP)) u_pick (
            .req   (snap_q[g*MPP +: MPP]),
            .ptr   (rr_ptr_q[g]),
            .valid (pick_v[g]),
            .idx   (pick_idx[g])
        );
    end

    // Highest-priority group with live requests, and winner among the snapshot.
    always_comb begin
        elig_v   = 1'b0;
        elig_grp = '0;
        sel_v    = 1'b0;
        sel_grp  = '0;
        sel_idx  = '0;
        for (int g = N_PRIO - 1; g >= 0; g--) begin
            if (elig_any[g]) begin
                elig_v   = 1'b1;
                elig_grp = GW'(g);
            end
            if (pick_v[g]) begin
                sel_v   = 1'b1;
                sel_grp = GW'(g);
                sel_idx = pick_idx[g];
            end
        end
        own_grp = GW'(int'(mid_q) / MPP);
        preempt = elig_v && ((mid_q == MID_NONE) || (elig_grp < own_grp));
    end

    // Lowest-index finished split slave and lowest-index newly splitting slave.
    always_comb begin
        done_v  = 1'b0;
        done_sl = '0;
        cap_v   = 1'b0;
        cap_sl  = '0;
        for (int s = N_SLAVES - 1; s >= 0; s--) begin
            if (sl_st_q[s] == SL_DONE) begin
                done_v  = 1'b1;
                done_sl = SW'(s);
            end
            if ((sl_st_q[s] == SL_FREE) && slaves_in[s]) begin
                cap_v  = 1'b1;
                cap_sl = SW'(s);
            end
        end
    end

    // One-hot grant decode; MID_NONE lies outside the master range so it decodes to zero.
    always_comb begin
        m_grants = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_grants[i] = (grant_id_q == MW'(i));
        end
    end

    // Slave split tracking plus the arbitration FSM with its registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q        <= ST_IDLE;
            grant_id_q  <= MID_NONE;
            mid_q       <= MID_NONE;
            target_q    <= MID_NONE;
            split_ret_q <= 1'b0;
            tslave_q    <= '0;
            blocked_q   <= '0;
            snap_q      <= '0;
            win_grp_q   <= '0;
            win_idx_q   <= '0;
            pend_q      <= 1'b0;
            pend_sl_q   <= '0;
            to_cnt_q    <= '0;
            set_cnt_q   <= '0;
            slaves_out  <= '0;
            timeout_err <= 1'b0;
            for (int g = 0; g < N_PRIO; g++) begin
                rr_ptr_q[g] <= '0;
            end
            for (int s = 0; s < N_SLAVES; s++) begin
                sl_st_q[s]  <= SL_FREE;
                sl_own_q[s] <= MID_NONE;
            end
        end else begin
            slaves_out  <= '0;
            timeout_err <= 1'b0;

            for (int s = 0; s < N_SLAVES; s++) begin
                if ((sl_st_q[s] == SL_BUSY) && !slaves_in[s]) begin
                    sl_st_q[s] <= SL_DONE;
                end
            end
            // Only one split capture may be outstanding; others wait while still FREE.
            if (!pend_q && cap_v) begin
                sl_st_q[cap_sl] <= SL_BUSY;
                pend_q          <= 1'b1;
                pend_sl_q       <= cap_sl;
            end

            case (st_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        st_q <= ST_SPLIT_REC;
                    end else begin
                        if (bus_util && (mid_q != MID_NONE)) begin
                            mid_q      <= MID_NONE;
                            grant_id_q <= MID_NONE;
                        end
                        if (done_v) begin
                            st_q <= ST_SEARCH_S;
                        end else if (preempt) begin
                            // Freeze the request picture so later changes cannot move the target.
                            snap_q <= elig;
                            st_q   <= ST_SEARCH_M;
                        end
                    end
                end
                ST_SPLIT_REC: begin
                    sl_own_q[pend_sl_q] <= mid_q;
                    if (mid_q != MID_NONE) begin
                        blocked_q[mid_q] <= 1'b1;
                    end
                    grant_id_q <= MID_NONE;
                    pend_q     <= 1'b0;
                    st_q       <= ST_SPLIT_WAIT;
                end
                ST_SPLIT_WAIT: begin
                    if (bus_util) begin
                        mid_q <= MID_NONE;
                        st_q  <= ST_IDLE;
                    end
                end
                ST_SEARCH_S: begin
                    target_q    <= sl_own_q[done_sl];
                    tslave_q    <= done_sl;
                    split_ret_q <= 1'b1;
                    grant_id_q  <= MID_NONE;
                    st_q        <= ST_WAIT_FREE;
                end
                ST_SEARCH_M: begin
                    grant_id_q <= MID_NONE;
                    if (sel_v) begin
                        target_q    <= MW'(int'(sel_grp) * MPP + int'(sel_idx));
                        win_grp_q   <= sel_grp;
                        win_idx_q   <= sel_idx;
                        split_ret_q <= 1'b0;
                        st_q        <= ST_WAIT_FREE;
                    end else begin
                        st_q <= ST_IDLE;
                    end
                end
                ST_WAIT_FREE: begin
                    grant_id_q <= MID_NONE;
                    if (bus_util) begin
                        st_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    mid_q      <= target_q;
                    grant_id_q <= target_q;
                    to_cnt_q   <= '0;
                    if (!split_ret_q) begin
                        rr_ptr_q[win_grp_q] <= (win_idx_q == PW'(MPP - 1)) ? '0
                                                                            : win_idx_q + PW'(1);
                    end
                    st_q <= ST_PICKUP;
                end
                ST_PICKUP: begin
                    if (!bus_util) begin
                        if (split_ret_q) begin
                            slaves_out[tslave_q] <= 1'b1;
                            st_q                 <= ST_ACK;
                        end else begin
                            st_q <= ST_IDLE;
                        end
                    end else if (to_cnt_q >= TW'(TIMEOUT - 1)) begin
                        // Withdraw the offer; a split slave stays DONE and is retried.
                        grant_id_q  <= MID_NONE;
                        mid_q       <= MID_NONE;
                        timeout_err <= 1'b1;
                        st_q        <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                ST_ACK: begin
                    sl_st_q[tslave_q]  <= SL_FREE;
                    sl_own_q[tslave_q] <= MID_NONE;
                    if (target_q != MID_NONE) begin
                        blocked_q[target_q] <= 1'b0;
                    end
                    set_cnt_q <= '0;
                    st_q      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (set_cnt_q >= CW'(WAIT_CYCLES - 1)) begin
                        st_q <= ST_IDLE;
                    end else begin
                        set_cnt_q <= set_cnt_q + CW'(1);
                    end
                end
                default: begin
                    st_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/split_arbiter.md
SPLIT_ARBITER -- requirements
Module: split_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 12: number of masters, which must be a multiple of N_PRIO.
REQ-002 SHALL have parameter N_PRIO, default 3: number of priority groups; group g holds masters g*MPP to g*MPP+MPP-1, where MPP = N_MASTERS/N_PRIO; group 0 has the highest priority.
REQ-003 SHALL have parameter N_SLAVES, default 6: number of split-capable slaves.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum number of cycles a master has to pick up a grant.
REQ-005 SHALL have parameter WAIT_CYCLES, default 2: length of the settle gap after a split acknowledge.
REQ-006 SHALL use derived constants MW = clog2(N_MASTERS+1) and MID_NONE = all-ones over MW bits.
REQ-007 clk  in  1  clock; rising edge.
REQ-008 rstn  in  1  reset; asynchronous, active-low.
REQ-009 m_reqs  in  N_MASTERS  per-master bus request.
REQ-010 m_grants  out  N_MASTERS  one-hot grant; all zero when no master is granted.
REQ-011 bus_util  in  1  bus-free flag: 1 = bus idle, 0 = bus driven by a master.
REQ-012 slaves_in  in  N_SLAVES  split flag: high while a slave holds a split transaction.
REQ-013 slaves_out  out  N_SLAVES  one-cycle split-acknowledge pulse.
REQ-014 state  out  4  current FSM state encoding.
REQ-015 mid_current  out  MW  current bus owner ID, or MID_NONE.
REQ-016 timeout_err  out  1  one-cycle pulse on grant-pickup timeout.

Function
REQ-017 SHALL treat a master as eligible when req & ~blocked; each master's blocked bit is set while that master owns a split slave.
REQ-018 SHALL implement FSM states IDLE, SPLIT_REC, SPLIT_WAIT, SEARCH_S, SEARCH_M, WAIT_FREE, GRANT, PICKUP, ACK, SETTLE.
REQ-019 In IDLE, SHALL take the first matching branch, in this order:
- pending split capture -> SPLIT_REC;
- any slave DONE -> SEARCH_S;
- an eligible request in a group strictly higher priority than the owner's group, or any eligible request when mid_current = MID_NONE -> SEARCH_M;
- otherwise stay in IDLE.
REQ-020 In IDLE, SHALL set mid_current and the grant to MID_NONE when bus_util = 1 while an owner exists.
REQ-021 In SEARCH_M, SHALL pick the highest-priority group with an eligible request and choose within it round-robin from that group's pointer.
REQ-022 On a grant from group g, SHALL set the group-g pointer to (winner index in group + 1) mod MPP.
REQ-023 In SEARCH_S, SHALL pick the lowest-index DONE slave, target its recorded owner, and flag the transfer as a split return.
REQ-024 WAIT_FREE SHALL hold the grant at none until bus_util = 1, then go to GRANT.
REQ-025 GRANT SHALL last one cycle, load mid_current and the grant with the target, then go to PICKUP.
REQ-026 m_grants SHALL be a combinational one-hot decode of the registered grant ID, with no extra cycle of latency.
REQ-027 In PICKUP, bus_util = 0 SHALL go to ACK for a split return and to IDLE otherwise.
REQ-028 PICKUP SHALL count cycles; after TIMEOUT cycles without pickup it SHALL:
- revoke the grant;
- set mid_current to MID_NONE;
- pulse timeout_err;
- go to IDLE, leaving the split slave DONE so it is retried.
REQ-029 ACK SHALL drive slaves_out[s] = 1 for exactly one cycle, then go to SETTLE.
REQ-030 On leaving ACK, SHALL set slave s to FREE, clear its owner, and unblock the master.
REQ-031 SETTLE SHALL last exactly WAIT_CYCLES cycles, then go to IDLE.
REQ-032 Slave tracking SHALL run every cycle, independent of FSM state:
- FREE and slaves_in = 1 -> BUSY, and raise a pending capture of that slave ID;
- BUSY and slaves_in = 0 -> DONE.
REQ-033 When several slaves assert simultaneously, SHALL capture only the lowest-index one; the others stay FREE and are captured on later cycles while their slaves_in remains high.
REQ-034 A new capture SHALL NOT be accepted while a previous capture is still pending.
REQ-035 SPLIT_REC SHALL record mid_current as the slave's owner, set the owner's blocked bit, drop the grant, clear the pending capture, and go to SPLIT_WAIT.
REQ-036 SPLIT_WAIT SHALL wait for bus_util = 1, then set mid_current to MID_NONE and go to IDLE.
REQ-037 Request changes during SEARCH, GRANT or PICKUP SHALL NOT alter the chosen target.
REQ-038 SHALL have no undefined states; any illegal encoding returns to IDLE.

Reset
REQ-039 On rstn = 0, asynchronously and regardless of state, SHALL set:
- state to IDLE;
- m_grants, slaves_out and timeout_err to 0;
- mid_current to MID_NONE;
- all slaves FREE with owner MID_NONE;
- blocked bits, round-robin pointers, counters and pending flags to 0.

Structure
REQ-040 A shared package bus_ctrl_pkg SHALL hold the FSM state enum, the slave-state enum (FREE/BUSY/DONE) and the MID_NONE width function.
REQ-041 A sub-module rr_picker (parameter WIDTH) SHALL provide the round-robin one-hot-to-index pick, instantiated once per priority group.

Verification
REQ-042 Default parameters, with m_reqs bits 5 and 9 high and bus free: SHALL grant master 5 only; master 9 is not granted while master 5 owns the bus.
REQ-043 Masters 4 and 6 requesting continuously, each releasing the bus after pickup: grants SHALL alternate 4, 6, 4, 6.
REQ-044 Master 2 owns the bus and slaves_in[3] rises: master 2 SHALL be blocked and mid_current SHALL become MID_NONE once the bus is free.
REQ-045 Continuing REQ-044, slaves_in[3] falls: master 2 SHALL be regranted, slaves_out[3] SHALL pulse once after pickup, and master 2 SHALL be unblocked.
REQ-046 Master 0 granted with bus_util held at 1 for 255 cycles: timeout_err SHALL pulse, m_grants SHALL become 0, and state SHALL return to IDLE.
REQ-047 rstn asserted during ACK: slaves_out SHALL be 0 immediately and all slaves FREE.
